// File: rtl/result_requant.sv
// Requantises a captured SIZE x SIZE int32 accumulator matrix into int8 rows,
// streamed out one row per handshake with rounding, optional ReLU and saturation tracking.
module result_requant #(
    parameter  int SIZE  = 64,
    parameter  int SAT_W = 16,
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SIZE-1:0][SIZE-1:0][31:0]  acc_in,
    input  logic                             acc_in_rdy,
    output logic                             acc_in_pop,
    input  logic [4:0]                       cfg_shift,
    input  logic                             cfg_relu_en,
    output logic [SIZE-1:0][7:0]             row_out,
    output logic [IDX_W-1:0]                 row_idx,
    output logic                             row_last,
    output logic                             row_valid,
    input  logic                             row_ready,
    output logic                             busy,
    output logic [SAT_W-1:0]                 sat_count,
    input  logic                             sat_clear
);

    typedef enum logic [1:0] {IDLE, CAPTURE, EMIT} state_t;

    typedef struct packed {
        logic       sat;
        logic [7:0] q;
    } rq_t;

    // ReLU, round-half-up arithmetic shift in 33 bits, then clamp to int8.
    function automatic rq_t requant(input logic signed [31:0] x,
                                    input logic [4:0]         shift,
                                    input logic               relu_en);
        logic signed [32:0] v;
        logic signed [32:0] rnd;
        logic signed [32:0] y;
        rq_t                r;
        v     = (relu_en && x[31]) ? 33'sd0 : $signed({x[31], x});
        rnd   = (shift == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift - 5'd1));
        y     = (v + rnd) >>> shift;
        r.sat = (y > 33'sd127) || (y < -33'sd128);
        r.q   = r.sat ? (y[32] ? 8'h80 : 8'h7f) : y[7:0];
        return r;
    endfunction

    state_t           state;
    state_t           phase;
    logic [4:0]       shift_q;
    logic             relu_q;
    logic             row_sat;
    logic [IDX_W-1:0] next_idx;
    logic [4:0]       sel_shift;
    logic             sel_relu;
    logic             next_sat;
    rq_t              row_rq [SIZE];
    logic [31:0]      mat_buf [SIZE][SIZE];

    // CAPTURE is the single cycle in which IDLE sees a ready FIFO head:
    // the pop, the matrix capture and the row-0 load all share its closing edge.
    // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
    always_comb begin
        phase = state;
        if (state == IDLE && acc_in_rdy)
            phase = CAPTURE;
    end

    assign acc_in_pop = (phase == CAPTURE) && !rst;
    assign busy       = acc_in_pop || (state == EMIT);
    assign next_idx   = row_idx + IDX_W'(1);

    // Row 0 is requantised straight from the FIFO head with the live cfg;
    // later rows come from the buffer with the cfg frozen at capture.
    always_comb begin
        sel_shift = (phase == CAPTURE) ? cfg_shift   : shift_q;
        sel_relu  = (phase == CAPTURE) ? cfg_relu_en : relu_q;
        next_sat  = 1'b0;
        for (int c = 0; c < SIZE; c++) begin
            row_rq[c] = requant((phase == CAPTURE) ? acc_in[0][c] : mat_buf[next_idx][c],
                                sel_shift, sel_relu);
            next_sat  = next_sat | row_rq[c].sat;
        end
    end

    // NOTE: the matrix buffer is plain storage with no reset; its content is don't-care until captured.
    always_ff @(posedge clk) begin
        if (phase == CAPTURE) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    mat_buf[r][c] <= acc_in[r][c];
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row_valid <= 1'b0;
            row_last  <= 1'b0;
            row_idx   <= '0;
            row_out   <= '0;
            row_sat   <= 1'b0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            sat_count <= '0;
        end else begin
            case (phase)
                CAPTURE: begin
                    shift_q   <= cfg_shift;
                    relu_q    <= cfg_relu_en;
                    state     <= EMIT;
                    row_valid <= 1'b1;
                    row_idx   <= '0;
                    row_last  <= (SIZE == 1);
                    for (int c = 0; c < SIZE; c++)
                        row_out[c] <= row_rq[c].q;
                    row_sat   <= next_sat;
                end
                EMIT: begin
                    if (row_ready) begin
                        if (row_last) begin
                            state     <= IDLE;
                            row_valid <= 1'b0;
                            row_last  <= 1'b0;
                        end else begin
                            row_idx  <= next_idx;
                            row_last <= (next_idx == IDX_W'(SIZE - 1));
                            for (int c = 0; c < SIZE; c++)
                                row_out[c] <= row_rq[c].q;
                            row_sat  <= next_sat;
                        end
                    end
                end
                default: ;
            endcase

            // Clear has priority over a coincident increment; the counter sticks at all-ones.
            if (sat_clear)
                sat_count <= '0;
            else if (row_valid && row_ready && row_sat && !(&sat_count))
                sat_count <= sat_count + SAT_W'(1);
        end
    end

endmodule

// File: tb/tb_result_requant.sv
// Randomised scoreboard bench for result_requant: a negedge monitor models pops,
// row stream and sat_count from plain arithmetic and checks every DUT cycle.
module tb_result_requant;

    localparam int SIZE    = 64;
    localparam int SAT_W   = 16;
    localparam int IDX_W   = $clog2(SIZE);
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    logic                             clk = 1'b0;
    logic                             rst = 1'b1;
    logic [SIZE-1:0][SIZE-1:0][31:0]  acc_in = '0;
    logic                             acc_in_rdy = 1'b0;
    logic                             acc_in_pop;
    logic [4:0]                       cfg_shift = '0;
    logic                             cfg_relu_en = 1'b0;
    logic [SIZE-1:0][7:0]             row_out;
    logic [IDX_W-1:0]                 row_idx;
    logic                             row_last;
    logic                             row_valid;
    logic                             row_ready = 1'b1;
    logic                             busy;
    logic [SAT_W-1:0]                 sat_count;
    logic                             sat_clear = 1'b0;

    typedef struct {
        logic [SIZE-1:0][7:0] data;
        int                   idx;
        bit                   sat;
    } exp_row_t;

    exp_row_t             exp_q[$];
    exp_row_t             mon_e;
    int                   n_cmp = 0;
    int                   n_fail = 0;
    int                   cyc = 0;
    int                   pops = 0;
    int                   pop_cyc = -1;
    int                   last_xfer_cyc = -1;
    int                   sat_model = 0;
    int                   bad_col;
    bit                   bp_mode = 1'b0;
    bit                   mon_exp_pop;
    bit                   stalled = 1'b0;
    logic [SIZE-1:0][7:0] held_row;
    logic [IDX_W-1:0]     held_idx;
    logic [8:0]           q9;

    result_requant #(.SIZE(SIZE), .SAT_W(SAT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .acc_in     (acc_in),
        .acc_in_rdy (acc_in_rdy),
        .acc_in_pop (acc_in_pop),
        .cfg_shift  (cfg_shift),
        .cfg_relu_en(cfg_relu_en),
        .row_out    (row_out),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .busy       (busy),
        .sat_count  (sat_count),
        .sat_clear  (sat_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: {saturated, int8}. Rounding is floor((v + 2^(s-1)) / 2^s) in plain integers.
    function automatic logic [8:0] ref_q(input int x, input int sh, input bit relu);
        longint v, d, n, y;
        v = (relu && x < 0) ? 0 : x;
        if (sh == 0) begin
            y = v;
        end else begin
            d = longint'(1) << sh;
            n = v + d / 2;
            y = n / d;
            if ((n % d) != 0 && n < 0) y = y - 1;
        end
        if (y > 127)  return {1'b1, 8'h7f};
        if (y < -128) return {1'b1, 8'h80};
        return {1'b0, y[7:0]};
    endfunction

    // Monitor / scoreboard: all expectations derive from sampled inputs and the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            sat_model = 0;
            stalled   = 1'b0;
        end else begin
            mon_exp_pop = acc_in_rdy && (exp_q.size() == 0);
            check(row_valid == (exp_q.size() != 0), "row_valid", row_valid, exp_q.size() != 0);
            check(acc_in_pop == mon_exp_pop, "acc_in_pop", acc_in_pop, mon_exp_pop);
            check(busy == (mon_exp_pop || exp_q.size() != 0), "busy", busy,
                  mon_exp_pop || exp_q.size() != 0);
            check(sat_count == SAT_W'(sat_model), "sat_count", sat_count, sat_model);
            if (acc_in_pop && !acc_in_rdy)
                check(1'b0, "pop_without_rdy", 1, 0);

            if (stalled && row_valid)
                check(row_out == held_row && row_idx == held_idx, "stall_hold", row_idx, held_idx);
            stalled  = row_valid && !row_ready;
            held_row = row_out;
            held_idx = row_idx;

            if (row_valid && row_ready && exp_q.size() != 0) begin
                mon_e   = exp_q.pop_front();
                bad_col = -1;
                for (int c = 0; c < SIZE; c++)
                    if (bad_col < 0 && row_out[c] !== mon_e.data[c]) bad_col = c;
                if (bad_col < 0) bad_col = 0;
                check(row_out == mon_e.data, $sformatf("row %0d col %0d", mon_e.idx, bad_col),
                      $signed(row_out[bad_col]), $signed(mon_e.data[bad_col]));
                check(row_idx == IDX_W'(mon_e.idx), "row_idx", row_idx, mon_e.idx);
                check(row_last == (mon_e.idx == SIZE - 1), "row_last", row_last, mon_e.idx == SIZE - 1);
                if (mon_e.idx == SIZE - 1) last_xfer_cyc = cyc;
                if (mon_e.sat && sat_model != SAT_MAX) sat_model++;
            end
            if (sat_clear) sat_model = 0;

            if (acc_in_pop) begin
                pops++;
                pop_cyc = cyc;
                for (int r = 0; r < SIZE; r++) begin
                    mon_e.idx = r;
                    mon_e.sat = 1'b0;
                    for (int c = 0; c < SIZE; c++) begin
                        q9 = ref_q($signed(acc_in[r][c]), int'(cfg_shift), cfg_relu_en);
                        mon_e.data[c] = q9[7:0];
                        mon_e.sat     = mon_e.sat | q9[8];
                    end
                    exp_q.push_back(mon_e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            row_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

    task automatic fill_random();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                int v;
                v = int'($urandom);
                acc_in[r][c] = 32'(v >>> $urandom_range(6, 28));
            end
    endtask

    task automatic wait_pop(input string name);
        int start;
        int n;
        start = pops;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (pops == start && n < 400);
        check(pops != start, {"pop_timeout ", name}, pops - start, 1);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || row_valid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(exp_q.size() == 0 && !row_valid, {"drain_timeout ", name}, exp_q.size(), 0);
    endtask

    task automatic run_matrix(input int shift, input bit relu, input string name);
        cfg_shift   = 5'(shift);
        cfg_relu_en = relu;
        acc_in_rdy  = 1'b1;
        wait_pop(name);
        acc_in_rdy  = 1'b0;
        wait_drain(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(row_valid == 1'b0,  {tag, " row_valid"}, row_valid, 0);
        check(row_last == 1'b0,   {tag, " row_last"}, row_last, 0);
        check(busy == 1'b0,       {tag, " busy"}, busy, 0);
        check(acc_in_pop == 1'b0, {tag, " acc_in_pop"}, acc_in_pop, 0);
        check(row_idx == '0,      {tag, " row_idx"}, row_idx, 0);
        check(row_out == '0,      {tag, " row_out"}, row_out[0], 0);
        check(sat_count == '0,    {tag, " sat_count"}, sat_count, 0);
    endtask

    initial begin
        int pops0;
        int n;

        // Reset state, with a ready FIFO head that must not be popped.
        repeat (3) @(posedge clk);
        #1 acc_in_rdy = 1'b1;
        #1 check_reset_outputs("reset");
        acc_in_rdy = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Ramp matrix: row r yields r in every column.
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                acc_in[r][c] = 32'(r * 256 + c);
        pops0 = pops;
        run_matrix(8, 1'b0, "ramp");
        check(pops == pops0 + 1, "ramp_pop_count", pops - pops0, 1);

        // Rounding edges at shift 8.
        fill_random();
        acc_in[0][0] = 32'(383);
        acc_in[0][1] = 32'(384);
        acc_in[0][2] = 32'(-384);
        run_matrix(8, 1'b0, "rounding");

        // Saturation at shift 0.
        fill_random();
        acc_in[1][0] = 32'(40000);
        acc_in[1][1] = 32'(-40000);
        run_matrix(0, 1'b0, "saturate");

        // ReLU on then off over the same negative values.
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                acc_in[r][c] = (c % 2 == 0) ? 32'(-1000) : 32'(int'($urandom_range(0, 400)));
        run_matrix(2, 1'b1, "relu_on");
        run_matrix(2, 1'b0, "relu_off");

        // Random backpressure on the row stream.
        bp_mode = 1'b1;
        fill_random();
        run_matrix(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "backpressure");
        bp_mode = 1'b0;

        // Back-to-back matrices; the shift change during matrix 1 belongs to matrix 2.
        fill_random();
        cfg_shift   = 5'd4;
        cfg_relu_en = 1'b0;
        acc_in_rdy  = 1'b1;
        wait_pop("b2b_first");
        fill_random();
        @(posedge clk);
        #1 cfg_shift = 5'd12;
        wait_pop("b2b_second");
        check(pop_cyc == last_xfer_cyc + 1, "b2b_pop_gap", pop_cyc - last_xfer_cyc, 1);
        acc_in_rdy = 1'b0;
        wait_drain("b2b");

        // Reset in the middle of emission, then a fresh matrix restarts at row 0.
        fill_random();
        cfg_shift  = 5'd6;
        acc_in_rdy = 1'b1;
        wait_pop("pre_reset");
        acc_in_rdy = 1'b0;
        n = 0;
        while (!(row_valid && row_idx == IDX_W'(10)) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(row_valid && row_idx == IDX_W'(10), "reach_row10", row_idx, 10);
        #1 rst = 1'b1;
        acc_in_rdy = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        fill_random();
        cfg_shift = 5'd10;
        wait_pop("post_reset");
        acc_in_rdy = 1'b0;
        wait_drain("post_reset");

        // Every row saturates; clear lands on the final row transfer and must win.
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                acc_in[r][c] = 32'(40000);
        cfg_shift  = 5'd0;
        acc_in_rdy = 1'b1;
        wait_pop("sat_clear");
        acc_in_rdy = 1'b0;
        n = 0;
        while (!(row_valid && row_last) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(row_valid && row_last, "reach_last_row", row_last, 1);
        sat_clear = 1'b1;
        @(posedge clk);
        #1 sat_clear = 1'b0;
        wait_drain("sat_clear");
        check(sat_count == '0, "sat_clear_wins", sat_count, 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/result_requant.md
RESULT_REQUANT -- requirements
Module: result_requant

Interface
REQ-001 SHALL have parameter SIZE, default 64, giving the systolic array dimension (matrix is SIZE x SIZE).
REQ-002 SHALL have parameter SAT_W, default 16, giving the saturation counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 acc_in  input  [SIZE][SIZE] x 32  signed accumulator matrix from the MMU result FIFO head; valid while acc_in_rdy=1.
REQ-006 acc_in_rdy  input  1  result FIFO non-empty.
REQ-007 acc_in_pop  output  1  one-cycle pop strobe to the result FIFO.
REQ-008 cfg_shift  input  5  arithmetic right-shift amount, 0..31.
REQ-009 cfg_relu_en  input  1  1 = clamp negative accumulators to 0 before shifting.
REQ-010 row_out  output  [SIZE] x 8  signed int8 activation row.
REQ-011 row_idx  output  clog2(SIZE)  index of the row on row_out.
REQ-012 row_last  output  1  row_idx == SIZE-1 while row_valid=1.
REQ-013 row_valid / row_ready  output / input  1 each  valid/ready handshake for the row stream; transfer occurs when both are 1.
REQ-014 busy  output  1  high from the capture cycle through the last-row transfer.
REQ-015 sat_count  output  SAT_W  count of emitted rows containing at least one saturated element.
REQ-016 sat_clear  input  1  synchronous clear of sat_count.

Function
REQ-017 SHALL implement FSM IDLE -> CAPTURE -> EMIT -> IDLE.
REQ-018 IDLE: when acc_in_rdy=1, SHALL assert acc_in_pop for exactly one cycle, register all of acc_in into an internal matrix buffer, register cfg_shift/cfg_relu_en on the same edge, and move to EMIT.
REQ-019 acc_in_pop SHALL never be asserted when acc_in_rdy=0 or outside IDLE.
REQ-020 cfg_* changes after capture SHALL NOT affect the matrix in flight.
REQ-021 EMIT: row_valid SHALL rise in the cycle after the capture edge with row 0; row r is emitted in ascending order 0..SIZE-1.
REQ-022 The output row register SHALL reload the next row on the same edge as a transfer (back-to-back rows, one per cycle at row_ready=1).
REQ-023 While row_valid=1 and row_ready=0, row_out, row_idx and row_last SHALL hold stable.
REQ-024 Transfer of row SIZE-1 SHALL return the FSM to IDLE, deassert row_valid and busy on that edge; the next pop may occur in the following cycle (throughput SIZE+1 cycles per matrix).
REQ-025 Per element x (signed 32-bit): v = (relu_en and x<0) ? 0 : x.
REQ-026 shift=0: y = v; shift>0: y = (v + 2^(shift-1)) >>> shift, computed in 33-bit signed (no overflow; round half up).
REQ-027 Output = y saturated to [-128, 127]; an element is saturated when y is outside that range.
REQ-028 sat_count SHALL increment by 1 on each row transfer whose row has any saturated element, and SHALL stick at all-ones.
REQ-029 sat_clear SHALL zero sat_count next edge; simultaneous with an increment, clear wins.

Reset
REQ-030 On rst=1, asynchronously: FSM=IDLE, acc_in_pop=0, row_valid=0, row_last=0, busy=0, row_idx=0, row_out all 0, sat_count=0; buffer content is don't-care.
REQ-031 Reset asserted mid-EMIT SHALL abandon the matrix; no further rows are emitted for it; the popped matrix is not re-requested.

Verification
REQ-032 Single matrix, acc_in[r][c]=r*256+c, shift=8, relu off, row_ready=1 -> exactly one pop; rows 0..63 on consecutive cycles starting the cycle after the pop; row r elements = r (column 128..255 rounding yields r+1 for c>=128 and 0 <= value <= 127); row_last only on row 63.
REQ-033 Rounding/saturation: x=383, shift=8 -> 1; x=384 -> 2; x=-384 -> -1; x=40000, shift=0 -> 127, sat_count +1; x=-40000 -> -128.
REQ-034 ReLU: relu on, x=-1000, shift=2 -> 0 and no saturation counted; relu off -> -250.
REQ-035 Backpressure: row_ready toggled with a random pattern -> row_out/row_idx stable while stalled; all 64 rows delivered in order; no pop before the last transfer.
REQ-036 Back-to-back: acc_in_rdy held high for two matrices -> second pop exactly one cycle after the row-63 transfer; cfg_shift changed mid-matrix 1 takes effect only for matrix 2.
REQ-037 Reset at row 10 of EMIT -> all outputs 0 asynchronously; after release with acc_in_rdy=1, a new pop occurs and emission restarts at row 0; sat_clear coincident with a saturating transfer -> sat_count=0.
